phase_decoder: RTL and testbench

//   Reader side of the stepper phase interface: samples the 4-bit coil-phase bus driven to the motor.

---
 rtl/phase_decoder_pkg.sv | 58 +++++
 rtl/phase_sync_filter.sv | 58 +++++
 rtl/phase_decoder.sv | 119 +++++++++++
 tb/tb_phase_decoder.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/phase_decoder_pkg.sv
// Shared phase-code constants, FSM and fault encodings for the stepper phase interface.
// The driver side uses the same eight phase codes.
package phase_decoder_pkg;

  localparam logic [3:0] PH_1   = 4'b1000;
  localparam logic [3:0] PH_2   = 4'b1010;
  localparam logic [3:0] PH_3   = 4'b0010;
  localparam logic [3:0] PH_4   = 4'b0110;
  localparam logic [3:0] PH_5   = 4'b0100;
  localparam logic [3:0] PH_6   = 4'b0101;
  localparam logic [3:0] PH_7   = 4'b0001;
  localparam logic [3:0] PH_8   = 4'b1001;
  localparam logic [3:0] PH_OFF = 4'b0000;

  typedef enum logic [1:0] {
    S_UNREF = 2'd0,
    S_TRACK = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    FAULT_NONE    = 2'b00,
    FAULT_ILLEGAL = 2'b01,
    FAULT_SKIP    = 2'b10
  } fault_t;

  typedef enum logic [1:0] {
    CODE_OFF     = 2'd0,
    CODE_LEGAL   = 2'd1,
    CODE_ILLEGAL = 2'd2
  } code_kind_t;

  typedef struct packed {
    code_kind_t kind;
    logic [2:0] idx;
  } code_info_t;

  // idx is the zero-based position in the half-step sequence (PH_1 -> 0).
  function automatic code_info_t decode_phase(input logic [3:0] code);
    code_info_t info;
    info.kind = CODE_LEGAL;
    info.idx  = 3'd0;
    case (code)
      PH_1:    info.idx = 3'd0;
      PH_2:    info.idx = 3'd1;
      PH_3:    info.idx = 3'd2;
      PH_4:    info.idx = 3'd3;
      PH_5:    info.idx = 3'd4;
      PH_6:    info.idx = 3'd5;
      PH_7:    info.idx = 3'd6;
      PH_8:    info.idx = 3'd7;
      PH_OFF:  info.kind = CODE_OFF;
      default: info.kind = CODE_ILLEGAL;
    endcase
    return info;
  endfunction

endpackage

// File: rtl/phase_sync_filter.sv
// Synchronizes the asynchronous phase bus and emits the accepted code with a new_code strobe.
// DEBOUNCE_EN adds a stability counter: a code must hold STABLE_CYCLES edges before acceptance.
module phase_sync_filter #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] phase_in,
  output logic [3:0] code,
  output logic       new_code
);

  logic [3:0] sync_q [SYNC_STAGES];
  logic [3:0] accepted_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 4'b0000;
    end else begin
      sync_q[0] <= phase_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

`ifdef DEBOUNCE_EN
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

  logic [3:0]    cand_q;
  logic [CW-1:0] cnt_q;

  // cnt_q counts consecutive edges on which the synchronizer showed cand_q.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cand_q <= 4'b0000;
      cnt_q  <= CNT_MAX;
    end else if (sync_q[SYNC_STAGES-1] != cand_q) begin
      cand_q <= sync_q[SYNC_STAGES-1];
      cnt_q  <= CW'(1);
    end else if (cnt_q != CNT_MAX) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign code     = cand_q;
  assign new_code = (cnt_q == CNT_MAX) && (cand_q != accepted_q);
`else
  assign code     = sync_q[SYNC_STAGES-1];
  assign new_code = (code != accepted_q);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          accepted_q <= 4'b0000;
    else if (new_code) accepted_q <= code;
  end

endmodule

// File: rtl/phase_decoder.sv
// Stepper phase-bus reader: decodes half-step codes into step events, direction, size and position.
// Optional DEBOUNCE_EN macro enables input stability filtering in phase_sync_filter.
module phase_decoder
  import phase_decoder_pkg::*;
#(
  parameter int POS_WIDTH     = 16,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           phase_in,
  input  logic                 clear_pos,
  input  logic                 fault_clr,
  output logic [POS_WIDTH-1:0] position,
  output logic                 step_valid,
  output logic                 step_dir,
  output logic                 step_full,
  output logic                 energized,
  output logic                 fault,
  output logic [1:0]           fault_code,
  output logic [1:0]           dbg_state
);

  logic       code_new;
  logic [3:0] code;

  phase_sync_filter #(
    .SYNC_STAGES   (SYNC_STAGES),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_filter (
    .clk      (clk),
    .rst      (rst),
    .phase_in (phase_in),
    .code     (code),
    .new_code (code_new)
  );

  code_info_t info;
  state_t     state_q;
  logic [2:0] last_idx_q;
  logic [2:0] delta;
  logic       step_hit, step_cw, step_big, skip_hit, new_fault;
  fault_t     new_fault_code;
  logic [POS_WIDTH-1:0] step_mag;

  assign info  = decode_phase(code);
  assign delta = info.idx - last_idx_q;

  always_comb begin
    step_hit = 1'b0;
    step_cw  = 1'b0;
    step_big = 1'b0;
    skip_hit = 1'b0;
    if (code_new && info.kind == CODE_LEGAL && state_q != S_UNREF) begin
      case (delta)
        3'd1: begin step_hit = 1'b1; step_cw = 1'b1; end
        3'd2: begin step_hit = 1'b1; step_cw = 1'b1; step_big = 1'b1; end
        3'd7: step_hit = 1'b1;
        3'd6: begin step_hit = 1'b1; step_big = 1'b1; end
        3'd3, 3'd4, 3'd5: skip_hit = 1'b1;
        default: ;
      endcase
    end
  end

  assign new_fault      = skip_hit || (code_new && info.kind == CODE_ILLEGAL);
  assign new_fault_code = skip_hit ? FAULT_SKIP : FAULT_ILLEGAL;
  assign step_mag       = step_big ? POS_WIDTH'(2) : POS_WIDTH'(1);

  // step_valid is a one-cycle strobe with no back-pressure: step_dir, step_full and
  // position are valid in the same cycle and hold until the next strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_UNREF;
      last_idx_q <= 3'd0;
      position   <= '0;
      step_valid <= 1'b0;
      step_dir   <= 1'b0;
      step_full  <= 1'b0;
      energized  <= 1'b0;
      fault      <= 1'b0;
      fault_code <= FAULT_NONE;
    end else begin
      step_valid <= step_hit;
      if (step_hit) begin
        step_dir  <= step_cw;
        step_full <= step_big;
      end

      if (clear_pos)     position <= '0;
      else if (step_hit) position <= step_cw ? position + step_mag : position - step_mag;

      // First fault is kept; a fault arriving with fault_clr replaces the old one.
      if (new_fault && (!fault || fault_clr)) begin
        fault      <= 1'b1;
        fault_code <= new_fault_code;
      end else if (fault_clr) begin
        fault      <= 1'b0;
        fault_code <= FAULT_NONE;
      end

      if (code_new) begin
        energized <= (info.kind != CODE_OFF);
        case (info.kind)
          CODE_LEGAL: begin
            last_idx_q <= info.idx;
            state_q    <= S_TRACK;
          end
          CODE_OFF: if (state_q == S_TRACK) state_q <= S_PAUSE;
          default: ;
        endcase
      end
    end
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_phase_decoder.sv
// Directed bench for phase_decoder: step expectations go into a queue, a monitor checks each strobe.
module tb_phase_decoder;

  localparam int W = 18;
`ifdef DEBOUNCE_EN
  localparam int LAT = 3 + 4;
`else
  localparam int LAT = 3;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  phase_in = 4'b0000;
  logic        clear_pos = 1'b0;
  logic        fault_clr = 1'b0;
  logic [15:0] position;
  logic        step_valid, step_dir, step_full, energized, fault;
  logic [1:0]  fault_code, dbg_state;

  logic [W-1:0] exp_q[$];
  logic [15:0]  model_pos = 16'h0;
  int tests_run = 0;
  int tests_failed = 0;

  phase_decoder dut (
    .clk        (clk),
    .rst        (rst),
    .phase_in   (phase_in),
    .clear_pos  (clear_pos),
    .fault_clr  (fault_clr),
    .position   (position),
    .step_valid (step_valid),
    .step_dir   (step_dir),
    .step_full  (step_full),
    .energized  (energized),
    .fault      (fault),
    .fault_code (fault_code),
    .dbg_state  (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_drained(input string name);
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    phase_in = 4'b0000;
    clear_pos = 1'b0;
    fault_clr = 1'b0;
    tick(2);
    rst = 1'b1;
    model_pos = 16'h0;
    tick(2);
  endtask

  // Driver tasks
  task automatic push_step(input logic dir, input logic full);
    if (dir) model_pos = model_pos + (full ? 16'd2 : 16'd1);
    else     model_pos = model_pos - (full ? 16'd2 : 16'd1);
    exp_q.push_back({dir, full, model_pos});
  endtask

  task automatic drive(input logic [3:0] code, input int hold);
    phase_in = code;
    tick(hold);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (step_valid) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL unexpected_step: got pos %0h dir %0b full %0b expected no step",
                 position, step_dir, step_full);
      end else begin
        check("step", {14'h0, step_dir, step_full, position}, {14'h0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    tick(2);
    rst = 1'b1;
    tick(1);
    check("rst_position", position, 0);
    check("rst_step_valid", step_valid, 0);
    check("rst_step_dir", step_dir, 0);
    check("rst_step_full", step_full, 0);
    check("rst_energized", energized, 0);
    check("rst_fault", {fault, fault_code}, 0);
    check("rst_state", dbg_state, 0);

    // 1: CW half steps
    drive(4'b1000, 10);
    check("t1_state_track", dbg_state, 1);
    check("t1_ref_no_step", position, 0);
    push_step(1'b1, 1'b0); drive(4'b1010, 10);
    push_step(1'b1, 1'b0); drive(4'b0010, 10);
    push_step(1'b1, 1'b0); drive(4'b0110, 10);
    check_drained("t1_drained");
    check("t1_dir", step_dir, 1);
    check("t1_full", step_full, 0);
    check("t1_position", position, 3);

    // 2: CCW full steps
    do_reset();
    drive(4'b1000, 10);
    push_step(1'b0, 1'b1); drive(4'b0001, 10);
    push_step(1'b0, 1'b1); drive(4'b0100, 10);
    push_step(1'b0, 1'b1); drive(4'b0010, 10);
    check_drained("t2_drained");
    check("t2_dir", step_dir, 0);
    check("t2_full", step_full, 1);
    check("t2_position", position, 16'hFFFA);

    // 3: index wrap 8 <-> 1
    do_reset();
    drive(4'b1001, 10);
    push_step(1'b1, 1'b0); drive(4'b1000, 10);
    check("t3_dir_cw", step_dir, 1);
    check("t3_pos_cw", position, 1);
    push_step(1'b0, 1'b0); drive(4'b1001, 10);
    check_drained("t3_drained");
    check("t3_dir_ccw", step_dir, 0);
    check("t3_pos_ccw", position, 0);

    // 4: pause/resume, clear_pos colliding with a step
    do_reset();
    drive(4'b0110, 10);
    check("t4_energized_a", energized, 1);
    drive(4'b0000, 10);
    check("t4_energized_b", energized, 0);
    check("t4_state_pause", dbg_state, 2);
    drive(4'b0110, 10);
    check("t4_energized_c", energized, 1);
    check("t4_resume_no_step", position, 0);
    model_pos = 16'h0;
    exp_q.push_back({1'b1, 1'b0, 16'h0});
    phase_in = 4'b0100;
    tick(LAT - 1);
    clear_pos = 1'b1;
    tick(1);
    clear_pos = 1'b0;
    tick(8);
    check_drained("t4_drained");
    check("t4_energized_d", energized, 1);
    check("t4_position", position, 0);

    // 5: skipped phase then illegal code; first fault kept
    do_reset();
    drive(4'b1000, 10);
    drive(4'b0100, 10);
    check("t5_skip_fault", {fault, fault_code}, 3'b110);
    check("t5_skip_pos", position, 0);
    drive(4'b1111, 10);
    check("t5_first_kept", {fault, fault_code}, 3'b110);
    fault_clr = 1'b1;
    tick(1);
    fault_clr = 1'b0;
    tick(1);
    check("t5_cleared", {fault, fault_code}, 3'b000);
    drive(4'b0100, 10);
    drive(4'b1111, 10);
    check_drained("t5_drained");
    check("t5_illegal_fault", {fault, fault_code}, 3'b101);
    check("t5_state_kept", dbg_state, 1);
    check("t5_position", position, 0);

    // 6: 2-clock glitch
    do_reset();
    drive(4'b0010, 10);
`ifndef DEBOUNCE_EN
    push_step(1'b0, 1'b0);
`endif
    drive(4'b1010, 2);
`ifndef DEBOUNCE_EN
    push_step(1'b1, 1'b0);
`endif
    drive(4'b0010, 16);
    check_drained("t6_drained");
    check("t6_position", position, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
